// File: rtl/vga_pkg.sv
// Shared constants, address widths, FSM encoding and the block-address helper
// for the VGA block framebuffer controller.
package vga_pkg;

  localparam int FB_W    = 192;           // block columns per line
  localparam int FB_H    = 108;           // block rows per frame
  localparam int DEPTH   = FB_W * FB_H;   // words per bank (20736)
  localparam int X_W     = 8;             // disp_x width
  localparam int Y_W     = 7;             // disp_y width
  localparam int WORD_AW = 15;            // word address within one bank
  localparam int RAM_AW  = 16;            // physical RAM address (two banks)
  localparam int RGB_W   = 24;            // {r,g,b}

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  // y*192 + x built from two shifted copies of y; no multiplier is inferred.
  function automatic logic [WORD_AW-1:0] blk_word(input logic [Y_W-1:0] y,
                                                  input logic [X_W-1:0] x);
    logic [WORD_AW-1:0] y128;
    logic [WORD_AW-1:0] y64;
    logic [WORD_AW-1:0] xx;
    y128 = {1'b0, y, 7'b0};
    y64  = {2'b0, y, 6'b0};
    xx   = {7'b0, x};
    return y128 + y64 + xx;
  endfunction

endpackage

// File: rtl/vga_fb_ctrl_if.sv
// Host-side bus of the framebuffer controller: write channel, clear and swap
// commands, and status.
//
// Write channel handshake: the host raises wr_valid with wr_addr/wr_data and
// holds all three stable until the cycle in which wr_ready is also high; that
// cycle is the single transfer. wr_ready may drop at any time (display reads
// own the RAM port) and never depends on wr_valid.
interface vga_fb_ctrl_if;
  import vga_pkg::*;

  logic               wr_valid;
  logic               wr_ready;
  logic [WORD_AW-1:0] wr_addr;
  logic [RGB_W-1:0]   wr_data;
  logic               wr_drop;
  logic               clr_req;
  logic [RGB_W-1:0]   clr_color;
  logic               clr_done;
  logic               swap_req;
  logic               swap_done;
  logic               front_bank;
  logic               busy;

  // Controller side.
  modport slave (
    input  wr_valid, wr_addr, wr_data, clr_req, clr_color, swap_req,
    output wr_ready, wr_drop, clr_done, swap_done, front_bank, busy
  );

  // Host side.
  modport master (
    output wr_valid, wr_addr, wr_data, clr_req, clr_color, swap_req,
    input  wr_ready, wr_drop, clr_done, swap_done, front_bank, busy
  );
endinterface

// File: rtl/fb_ram.sv
// Single-port framebuffer RAM, one access per cycle, registered read data.
// Written as a plain array so synthesis maps it onto block RAM.
module fb_ram #(
  parameter int WORDS = 41472,
  parameter int AW    = 16,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [WORDS];
  logic [DW-1:0] r_q;

  // One port: a write cycle does not update the read register.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/vga_fb_ctrl.sv
// Double-buffered block framebuffer controller. The display scans the front
// bank with a fixed two-cycle latency; the host writes and the clear engine
// fill the back bank only in cycles the display leaves the RAM port free.
// A swap is deferred to the next frame_end so the display never tears.
module vga_fb_ctrl #(
  parameter int FB_W  = vga_pkg::FB_W,
  parameter int FB_H  = vga_pkg::FB_H,
  parameter int DEPTH = vga_pkg::DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    disp_req,
  input  logic [7:0]              disp_x,
  input  logic [6:0]              disp_y,
  output logic [23:0]             disp_rgb,
  output logic                    disp_vld,
  input  logic                    frame_end,
  vga_fb_ctrl_if.slave            host,
  output vga_pkg::state_t         o_dbg_state,
  output logic [14:0]             o_dbg_cnt
);

  vga_pkg::state_t r_state;
  logic            r_front_bank;
  logic [14:0]     r_cnt;
  logic            r_clr_done;
  logic            r_swap_done;
  logic            r_wr_drop;
  logic            r_p1_vld;
  logic            r_p1_oob;
  logic [23:0]     r_rgb;
  logic            r_vld;

  logic [14:0]     w_disp_word;
  logic            w_disp_in;
  logic            w_wr_ready;
  logic            w_host_fire;
  logic            w_host_addr_ok;
  logic            w_host_we;
  logic            w_clr_we;
  logic            w_ram_en;
  logic            w_ram_we;
  logic            w_bank_sel;
  logic [14:0]     w_word;
  logic [15:0]     w_ram_addr;
  logic [23:0]     w_ram_wdata;
  logic [23:0]     w_ram_q;

  // Display address and range check; out-of-range blocks never touch the RAM.
  assign w_disp_word = vga_pkg::blk_word(disp_y, disp_x);
  assign w_disp_in   = (32'(disp_x) < 32'(FB_W)) && (32'(disp_y) < 32'(FB_H));

  // The display always wins the port; writes only fill idle display cycles.
  assign w_wr_ready     = !disp_req && (r_state == vga_pkg::ST_IDLE) && !reset;
  assign w_host_fire    = host.wr_valid && w_wr_ready;
  assign w_host_addr_ok = 32'(host.wr_addr) < 32'(DEPTH);
  assign w_host_we      = w_host_fire && w_host_addr_ok;
  assign w_clr_we       = !disp_req && (r_state == vga_pkg::ST_CLEAR);
  assign w_ram_we       = w_host_we || w_clr_we;
  assign w_ram_en       = (disp_req && w_disp_in) || w_ram_we;

  // Reads use the current front bank, writes the opposite one.
  assign w_bank_sel  = disp_req ? r_front_bank : ~r_front_bank;
  assign w_word      = disp_req ? w_disp_word : (w_clr_we ? r_cnt : host.wr_addr);
  assign w_ram_wdata = w_clr_we ? host.clr_color : host.wr_data;
  // Bank 1 sits directly above bank 0, so the physical address is word+DEPTH.
  assign w_ram_addr  = w_bank_sel ? ({1'b0, w_word} + 16'(DEPTH)) : {1'b0, w_word};

  fb_ram #(
    .WORDS (2 * DEPTH),
    .AW    (16),
    .DW    (24)
  ) u_fb_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_q)
  );

  // Display pipeline: request, RAM read, output register (two-cycle latency).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p1_vld <= 1'b0;
      r_p1_oob <= 1'b0;
      r_rgb    <= '0;
      r_vld    <= 1'b0;
    end else begin
      r_p1_vld <= disp_req;
      r_p1_oob <= disp_req && !w_disp_in;
      r_vld    <= r_p1_vld;
      if (r_p1_vld && !r_p1_oob) r_rgb <= w_ram_q;
      else                       r_rgb <= '0;
    end
  end

  // Control FSM: clear sweep, deferred swap, and the registered status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= vga_pkg::ST_IDLE;
      r_front_bank <= 1'b0;
      r_cnt        <= '0;
      r_clr_done   <= 1'b0;
      r_swap_done  <= 1'b0;
      r_wr_drop    <= 1'b0;
    end else begin
      r_clr_done  <= 1'b0;
      r_swap_done <= 1'b0;
      if (w_host_fire && !w_host_addr_ok) r_wr_drop <= 1'b1;
      case (r_state)
        vga_pkg::ST_IDLE: begin
          // A clear outranks a swap requested in the same cycle.
          if (host.clr_req) begin
            r_state <= vga_pkg::ST_CLEAR;
            r_cnt   <= '0;
          end else if (host.swap_req) begin
            r_state <= vga_pkg::ST_PENDING;
          end
        end
        vga_pkg::ST_CLEAR: begin
          if (!disp_req) begin
            if (r_cnt == 15'(DEPTH - 1)) begin
              r_state    <= vga_pkg::ST_IDLE;
              r_cnt      <= '0;
              r_clr_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 15'd1;
            end
          end
        end
        vga_pkg::ST_PENDING: begin
          if (frame_end) begin
            r_front_bank <= ~r_front_bank;
            r_state      <= vga_pkg::ST_IDLE;
            r_swap_done  <= 1'b1;
          end
        end
        default: r_state <= vga_pkg::ST_IDLE;
      endcase
    end
  end

  assign disp_rgb        = r_rgb;
  assign disp_vld        = r_vld;
  assign host.wr_ready   = w_wr_ready;
  assign host.wr_drop    = r_wr_drop;
  assign host.clr_done   = r_clr_done;
  assign host.swap_done  = r_swap_done;
  assign host.front_bank = r_front_bank;
  assign host.busy       = (r_state != vga_pkg::ST_IDLE);
  assign o_dbg_state     = r_state;
  assign o_dbg_cnt       = r_cnt;

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Directed bench for vga_fb_ctrl: writes, swaps, clear, arbitration, range
// handling and asynchronous reset, each checked against hand-computed values.
module tb_vga_fb_ctrl;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [7:0]  disp_x;
  logic [6:0]  disp_y;
  logic [23:0] disp_rgb;
  logic        disp_vld;
  logic        frame_end;
  state_t      dbg_state;
  logic [14:0] dbg_cnt;

  int n_vec = 0;
  int n_err = 0;

  vga_fb_ctrl_if host_if ();

  vga_fb_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .disp_req    (disp_req),
    .disp_x      (disp_x),
    .disp_y      (disp_y),
    .disp_rgb    (disp_rgb),
    .disp_vld    (disp_vld),
    .frame_end   (frame_end),
    .host        (host_if),
    .o_dbg_state (dbg_state),
    .o_dbg_cnt   (dbg_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic host_write(input logic [14:0] addr, input logic [23:0] data);
    host_if.wr_valid = 1'b1;
    host_if.wr_addr  = addr;
    host_if.wr_data  = data;
    #1 chk("wr_ready_idle", 32'(host_if.wr_ready), 32'd1);
    tick();
    host_if.wr_valid = 1'b0;
  endtask

  task automatic disp_read(input string tag, input logic [7:0] x, input logic [6:0] y,
                           input logic [23:0] exp);
    disp_req = 1'b1;
    disp_x   = x;
    disp_y   = y;
    tick();
    disp_req = 1'b0;
    chk({tag, "_vld_n1"}, 32'(disp_vld), 32'd0);
    tick();
    chk({tag, "_vld_n2"}, 32'(disp_vld), 32'd1);
    chk({tag, "_rgb"}, 32'(disp_rgb), 32'(exp));
  endtask

  initial begin
    int n;
    logic seen;

    reset              = 1'b1;
    disp_req           = 1'b0;
    disp_x             = '0;
    disp_y             = '0;
    frame_end          = 1'b0;
    host_if.wr_valid   = 1'b0;
    host_if.wr_addr    = '0;
    host_if.wr_data    = '0;
    host_if.clr_req    = 1'b0;
    host_if.clr_color  = '0;
    host_if.swap_req   = 1'b0;

    // Reset state
    #12;
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_front", 32'(host_if.front_bank), 32'd0);
    chk("rst_busy", 32'(host_if.busy), 32'd0);
    chk("rst_wr_ready", 32'(host_if.wr_ready), 32'd0);
    chk("rst_vld", 32'(disp_vld), 32'd0);
    chk("rst_rgb", 32'(disp_rgb), 32'd0);
    chk("rst_drop", 32'(host_if.wr_drop), 32'd0);
    chk("rst_done", 32'({host_if.clr_done, host_if.swap_done}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Back-bank (bank 1) writes while front_bank=0
    host_write(15'd5, 24'hFF0000);

    // Display holds the port: wr_ready stays low until disp_req drops
    host_if.wr_valid = 1'b1;
    host_if.wr_addr  = 15'd6;
    host_if.wr_data  = 24'h0000AA;
    disp_req = 1'b1;
    disp_x   = 8'd0;
    disp_y   = 7'd0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("wr_ready_blocked", 32'(host_if.wr_ready), 32'd0);
      tick();
    end
    disp_req = 1'b0;
    #1 chk("wr_ready_freed", 32'(host_if.wr_ready), 32'd1);
    tick();
    host_if.wr_valid = 1'b0;

    // swap_req coincident with frame_end waits for the next frame_end
    host_if.swap_req = 1'b1;
    frame_end        = 1'b1;
    tick();
    host_if.swap_req = 1'b0;
    frame_end        = 1'b0;
    chk("swap_coinc_front", 32'(host_if.front_bank), 32'd0);
    chk("swap_coinc_state", 32'(dbg_state), 32'(ST_PENDING));
    chk("swap_coinc_busy", 32'(host_if.busy), 32'd1);
    tick();
    tick();
    chk("swap_wait_front", 32'(host_if.front_bank), 32'd0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("swap_front", 32'(host_if.front_bank), 32'd1);
    chk("swap_done", 32'(host_if.swap_done), 32'd1);
    chk("swap_busy", 32'(host_if.busy), 32'd0);
    tick();
    chk("swap_done_pulse", 32'(host_if.swap_done), 32'd0);

    // Front bank is now bank 1
    disp_read("rd_x5", 8'd5, 7'd0, 24'hFF0000);
    disp_read("rd_x6", 8'd6, 7'd0, 24'h0000AA);

    // Display request in the toggle cycle reads the pre-toggle bank
    host_write(15'd5, 24'h123456);
    host_if.swap_req = 1'b1;
    tick();
    host_if.swap_req = 1'b0;
    frame_end = 1'b1;
    disp_req  = 1'b1;
    disp_x    = 8'd5;
    disp_y    = 7'd0;
    tick();
    frame_end = 1'b0;
    disp_req  = 1'b0;
    chk("toggle_front", 32'(host_if.front_bank), 32'd0);
    tick();
    chk("toggle_rd_vld", 32'(disp_vld), 32'd1);
    chk("toggle_rd_rgb", 32'(disp_rgb), 32'h00FF0000);
    disp_read("rd_bank0", 8'd5, 7'd0, 24'h123456);

    // Out-of-range write is accepted and dropped; out-of-range reads are black
    host_write(15'd20736, 24'hABCDEF);
    chk("drop_set", 32'(host_if.wr_drop), 32'd1);
    tick();
    chk("drop_sticky", 32'(host_if.wr_drop), 32'd1);
    disp_read("oob_x200", 8'd200, 7'd0, 24'h000000);
    disp_read("oob_y108", 8'd0, 7'd108, 24'h000000);

    // Clear of bank 1 with a simultaneous swap_req (clear wins)
    host_if.clr_color = 24'h00FF00;
    host_if.clr_req   = 1'b1;
    host_if.swap_req  = 1'b1;
    tick();
    host_if.clr_req  = 1'b0;
    host_if.swap_req = 1'b0;
    chk("clr_state", 32'(dbg_state), 32'(ST_CLEAR));
    chk("clr_busy", 32'(host_if.busy), 32'd1);
    #1 chk("clr_wr_ready", 32'(host_if.wr_ready), 32'd0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 25000) begin
      host_if.swap_req = (n == 10);
      tick();
      n++;
      if (host_if.clr_done) seen = 1'b1;
    end
    host_if.swap_req = 1'b0;
    chk("clr_cycles", 32'(n), 32'd20736);
    chk("clr_end_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    chk("clr_done_pulse", 32'(host_if.clr_done), 32'd0);

    host_if.swap_req = 1'b1;
    tick();
    host_if.swap_req = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("clr_swap_front", 32'(host_if.front_bank), 32'd1);
    disp_read("clr_last", 8'd191, 7'd107, 24'h00FF00);
    disp_read("clr_x5", 8'd5, 7'd0, 24'h00FF00);
    disp_read("clr_first", 8'd0, 7'd0, 24'h00FF00);

    // Reset asserted mid-clear
    host_if.clr_req = 1'b1;
    tick();
    host_if.clr_req = 1'b0;
    repeat (1000) tick();
    chk("mid_cnt", 32'(dbg_cnt), 32'd1000);
    disp_req = 1'b1;
    disp_x   = 8'd1;
    disp_y   = 7'd1;
    tick();
    disp_req = 1'b0;
    chk("mid_cnt_hold", 32'(dbg_cnt), 32'd1000);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", 32'(host_if.busy), 32'd0);
    chk("async_front", 32'(host_if.front_bank), 32'd0);
    chk("async_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("async_cnt", 32'(dbg_cnt), 32'd0);
    chk("async_wr_ready", 32'(host_if.wr_ready), 32'd0);
    chk("async_drop", 32'(host_if.wr_drop), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    host_if.clr_req = 1'b1;
    tick();
    host_if.clr_req = 1'b0;
    chk("restart_state", 32'(dbg_state), 32'(ST_CLEAR));
    chk("restart_cnt0", 32'(dbg_cnt), 32'd0);
    tick();
    chk("restart_cnt1", 32'(dbg_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
